// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 OLED I2C path: engine states and display constants.
package oled_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, DATA, ACK_D, WAIT, STOP, DONE
  } state_t;

  // SSD1306 7-bit bus address and the two control bytes that prefix a stream
  localparam logic [6:0] SSD1306_ADDR = 7'h3C;
  localparam logic [7:0] CTRL_CMD     = 8'h00;
  localparam logic [7:0] CTRL_DATA    = 8'h40;

endpackage

// File: rtl/oled_i2c_master_if.sv
// Byte-stream handshake and status between the OLED sequencer (master) and the I2C engine (slave).
interface oled_i2c_master_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, busy, done, ack_err
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Divides clk down to SCL quarter periods and tracks the q0..q3 phase of the current bit cell.
module i2c_quarter_tick #(
  parameter int QDIV = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] phase
);
  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(QDIV - 1));

  // clear wins over counting so a new bit cell always starts at q0 with a full quarter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= '0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= '0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/oled_i2c_master.sv
// Write-only I2C byte engine for the SSD1306: START, address, data bytes with ACK checks, STOP.
module oled_i2c_master
  import oled_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         I2C_FREQ = 400_000,
  parameter logic [6:0] DEV_ADDR = SSD1306_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  oled_i2c_master_if.slave  bus,
  inout  wire               sda,
  output wire               scl
);
  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);

  state_t     state, state_next;
  logic       tick;
  logic [1:0] phase;
  logic       end_cell;
  logic       accept;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] byte_reg;
  logic       last_reg;
  logic       pending;
  logic       nack;
  logic       in_ready_r;
  logic       ack_err_r;
  logic       sda_low, scl_low;
  logic       sda_low_next, scl_low_next;

  i2c_quarter_tick #(.QDIV(QDIV)) u_qtick (
    .clk   (clk),
    .rst   (rst),
    .en    (state != IDLE),
    .clear (state == IDLE || (state == WAIT && tick)),
    .tick  (tick),
    .phase (phase)
  );

  assign end_cell = tick && (phase == 2'd3);
  assign accept   = bus.in_valid && (state == IDLE || (state == WAIT && !pending));

  assign bus.in_ready = in_ready_r;
  assign bus.ack_err  = ack_err_r;
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = (state == DONE);

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Pin levels are decoded here and registered below so sda/scl come straight from flops
  always_comb begin
    state_next   = state;
    sda_low_next = 1'b0;
    scl_low_next = 1'b0;
    case (state)
      IDLE:  if (bus.in_valid) state_next = START;
      START: begin
        sda_low_next = (phase != 2'd0);
        scl_low_next = (phase == 2'd3);
        if (end_cell) state_next = ADDR;
      end
      ADDR: begin
        sda_low_next = ~shreg[7];
        scl_low_next = ~phase[1];
        if (end_cell && bit_cnt == 3'd7) state_next = ACK_A;
      end
      ACK_A: begin
        scl_low_next = ~phase[1];
        if (end_cell) state_next = nack ? STOP : DATA;
      end
      DATA: begin
        sda_low_next = ~shreg[7];
        scl_low_next = ~phase[1];
        if (end_cell && bit_cnt == 3'd7) state_next = ACK_D;
      end
      ACK_D: begin
        scl_low_next = ~phase[1];
        if (end_cell) state_next = (nack || last_reg) ? STOP : WAIT;
      end
      WAIT: begin
        sda_low_next = 1'b1;
        scl_low_next = 1'b1;
        if (tick && pending) state_next = DATA;
      end
      STOP: begin
        sda_low_next = ~phase[1];
        scl_low_next = (phase == 2'd0);
        if (end_cell) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // pending marks a byte accepted in WAIT so a still-high in_valid is not taken twice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_low    <= 1'b0;
      scl_low    <= 1'b0;
      in_ready_r <= 1'b0;
      ack_err_r  <= 1'b0;
      byte_reg   <= '0;
      last_reg   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      nack       <= 1'b0;
      pending    <= 1'b0;
    end else begin
      sda_low    <= sda_low_next;
      scl_low    <= scl_low_next;
      in_ready_r <= accept;
      if (accept) begin
        byte_reg <= bus.in_data;
        last_reg <= bus.in_last;
      end
      if (state == IDLE && bus.in_valid) ack_err_r <= 1'b0;
      case (state)
        START: if (end_cell) begin
          shreg   <= {DEV_ADDR, 1'b0};
          bit_cnt <= '0;
        end
        ADDR, DATA: if (end_cell) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ACK_A, ACK_D: begin
          if (tick && phase == 2'd2) nack <= sda;
          if (end_cell) begin
            if (nack) ack_err_r <= 1'b1;
            if (state == ACK_A) shreg <= byte_reg;
          end
        end
        WAIT: begin
          if (accept) pending <= 1'b1;
          if (tick && pending) begin
            pending <= 1'b0;
            shreg   <= byte_reg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_oled_i2c_master.sv
// Bench for oled_i2c_master: an I2C slave model with selectable NACK and randomized byte streams.
module tb_oled_i2c_master;
  import oled_pkg::*;

  localparam int QDIV    = 31;
  localparam int TIMEOUT = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  oled_i2c_master_if bus ();
  wire sda;
  wire scl;
  pullup (sda);
  pullup (scl);

  logic slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;

  oled_i2c_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sda (sda),
    .scl (scl)
  );

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  logic       prev_sda = 1'b1;
  logic       prev_scl = 1'b1;
  int         bit_n    = 0;
  logic [7:0] sh       = '0;
  logic [7:0] rx_q[$];
  int         starts   = 0;
  int         stops    = 0;
  int         done_cnt = 0;
  longint     done_cyc = 0;
  int         nack_idx = -1;
  logic [7:0] stim [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: decodes START/STOP and bits from pin levels sampled once per cycle, ACKs every byte except nack_idx
  always @(negedge clk) begin
    if (rst) begin
      prev_sda  = 1'b1;
      prev_scl  = 1'b1;
      bit_n     = 0;
      slave_low = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda) begin
        starts++;
        bit_n = 0;
        rx_q.delete();
      end else if (prev_scl && scl && !prev_sda && sda) begin
        stops++;
      end else if (!prev_scl && scl) begin
        if (bit_n == 8) bit_n = 0;
        else begin
          sh = {sh[6:0], sda};
          bit_n++;
          if (bit_n == 8) rx_q.push_back(sh);
        end
      end else if (prev_scl && !scl) begin
        slave_low = 1'b0;
        if (bit_n == 8) slave_low = ((rx_q.size() - 1) != nack_idx);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_sda = sda;
      prev_scl = scl;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Sends stim[0..n-1]; nack_at selects which bus byte the slave refuses (0 = address, -1 = none)
  task automatic applyStimulus(input int n, input int nack_at, input int gap, input bit check_stall);
    int         accepted  = 0;
    int         d0        = done_cnt;
    longint     ready_cyc = 0;
    logic [7:0] exp_b[$];
    int         exp_rx, exp_acc, timer, high_cnt, bus_bytes, nchk;
    bit         abort     = 0;

    nack_idx = nack_at;
    starts   = 0;
    stops    = 0;
    exp_b.push_back({SSD1306_ADDR, 1'b0});
    for (int i = 0; i < n; i++) exp_b.push_back(stim[i]);
    exp_rx  = (nack_at < 0) ? n + 1 : nack_at + 1;
    exp_acc = (nack_at < 0) ? n : ((nack_at == 0) ? 1 : nack_at);

    for (int i = 0; i < n && !abort; i++) begin
      if (i > 0) begin
        timer = 0;
        while (!(rx_q.size() == i + 1 && !slave_low && scl == 1'b0) && done_cnt == d0 && timer < TIMEOUT) begin
          step();
          timer++;
        end
        if (timer >= TIMEOUT) begin
          checkOutput("gap_timeout", 32'(timer), 32'(0));
          abort = 1;
        end
        if (done_cnt != d0) abort = 1;
        high_cnt = 0;
        for (int k = 0; k < gap && !abort; k++) begin
          step();
          if (scl !== 1'b0) high_cnt++;
        end
        if (check_stall) checkOutput("stall_scl_high", 32'(high_cnt), 32'(0));
      end
      if (!abort) begin
        bus.in_data  = stim[i];
        bus.in_last  = (i == n - 1);
        bus.in_valid = 1'b1;
        timer = 0;
        do begin
          step();
          timer++;
        end while (!bus.in_ready && done_cnt == d0 && timer < TIMEOUT);
        if (bus.in_ready) begin
          accepted++;
          if (i == 0) begin
            ready_cyc = cyc;
            checkOutput("busy_start", 32'(bus.busy), 32'(1));
            checkOutput("ack_err_clr", 32'(bus.ack_err), 32'(0));
          end
        end else abort = 1;
        bus.in_valid = 1'b0;
      end
    end

    timer = 0;
    while (done_cnt == d0 && timer < TIMEOUT) begin
      step();
      timer++;
    end
    checkOutput("done_pulses", 32'(done_cnt - d0), 32'(1));
    step();
    checkOutput("done_width", 32'(bus.done), 32'(0));
    checkOutput("busy_end", 32'(bus.busy), 32'(0));
    checkOutput("ack_err", 32'(bus.ack_err), 32'(nack_at >= 0));
    checkOutput("ready_cnt", 32'(accepted), 32'(exp_acc));
    checkOutput("rx_cnt", 32'(rx_q.size()), 32'(exp_rx));
    nchk = (rx_q.size() < exp_rx) ? rx_q.size() : exp_rx;
    for (int j = 0; j < nchk; j++) checkOutput("rx_byte", 32'(rx_q[j]), 32'(exp_b[j]));
    checkOutput("starts", 32'(starts), 32'(1));
    checkOutput("stops", 32'(stops), 32'(1));
    bus_bytes = (nack_at == 0) ? 1 : n + 1;
    if ((n == 1 && nack_at < 0 && gap == 0) || nack_at == 0)
      checkOutput("latency", 32'(done_cyc - ready_cyc), 32'(QDIV * (8 + 36 * bus_bytes)));
    repeat (20) step();
    checkOutput("ack_err_sticky", 32'(bus.ack_err), 32'(nack_at >= 0));
  endtask

  initial begin
    int timer, act, n, nack;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    checkOutput("rst_sda", 32'(sda), 32'(1));
    checkOutput("rst_scl", 32'(scl), 32'(1));
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_ready", 32'(bus.in_ready), 32'(0));
    checkOutput("rst_done", 32'(bus.done), 32'(0));
    checkOutput("rst_ack_err", 32'(bus.ack_err), 32'(0));
    rst = 1'b0;
    repeat (5) step();

    $display("[TB] single byte 0xAE");
    stim[0] = 8'hAE;
    applyStimulus(1, -1, 0, 0);

    $display("[TB] three byte command stream");
    stim[0] = CTRL_CMD; stim[1] = 8'hAF; stim[2] = 8'hA6;
    applyStimulus(3, -1, 5, 0);

    $display("[TB] WAIT stall of 1000 cycles");
    stim[0] = CTRL_DATA; stim[1] = 8'h5A;
    applyStimulus(2, -1, 1000, 1);

    $display("[TB] address NACK");
    stim[0] = 8'h81;
    applyStimulus(1, 0, 0, 0);

    $display("[TB] data NACK on second of three bytes");
    stim[0] = CTRL_CMD; stim[1] = 8'h8D; stim[2] = 8'h14;
    applyStimulus(3, 2, 3, 0);

    $display("[TB] randomized streams");
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      nack = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
      applyStimulus(n, nack, $urandom_range(0, 30), 0);
    end

    $display("[TB] reset during DATA");
    nack_idx     = -1;
    bus.in_data  = 8'hAE;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    timer = 0;
    do begin
      step();
      timer++;
    end while (!bus.in_ready && timer < TIMEOUT);
    bus.in_valid = 1'b0;
    timer = 0;
    while (!(rx_q.size() == 1 && bit_n == 3) && timer < TIMEOUT) begin
      step();
      timer++;
    end
    checkOutput("reach_data_bit3", 32'(timer < TIMEOUT), 32'(1));
    rst = 1'b1;
    #1;
    checkOutput("midrst_sda", 32'(sda), 32'(1));
    checkOutput("midrst_scl", 32'(scl), 32'(1));
    checkOutput("midrst_busy", 32'(bus.busy), 32'(0));
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'(0));
    repeat (3) step();
    rst = 1'b0;
    act = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (sda !== 1'b1 || scl !== 1'b1 || bus.in_ready || bus.busy || bus.done) act++;
    end
    checkOutput("post_rst_quiet", 32'(act), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
